// File: rtl/rtc_pkg.sv
// Shared types and constants for the RTC time-set sequencer.
package rtc_pkg;

    typedef struct packed {
        logic [1:0] hr1;
        logic [3:0] hr0;
        logic [2:0] min1;
        logic [3:0] min0;
        logic [2:0] sec1;
        logic [3:0] sec0;
    } rtc_time_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        SET_SEC = 3'd3,
        COMMIT  = 3'd4
    } rtc_state_t;

    // Field limits held as two BCD digits {tens, ones}
    localparam logic [7:0] HR_MAX = 8'h23;
    localparam logic [7:0] MS_MAX = 8'h59;

    localparam int BLK_H0 = 0;
    localparam int BLK_H1 = 1;
    localparam int BLK_M0 = 2;
    localparam int BLK_M1 = 3;
    localparam int BLK_S0 = 4;
    localparam int BLK_S1 = 5;

endpackage

// File: rtl/rtc_bcd_step.sv
// Two-digit BCD increment/decrement with wrap at 00 and at a given maximum.
module rtc_bcd_step (
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    input  logic [7:0] max_i,
    input  logic       dec_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    always_comb begin
        tens_o = tens_i;
        ones_o = ones_i;
        if (dec_i) begin
            if (tens_i == 4'd0 && ones_i == 4'd0) begin
                tens_o = max_i[7:4];
                ones_o = max_i[3:0];
            end else if (ones_i == 4'd0) begin
                tens_o = tens_i - 4'd1;
                ones_o = 4'd9;
            end else begin
                ones_o = ones_i - 4'd1;
            end
        end else begin
            // >= rather than == so an out-of-range value still recovers to 00
            if ({tens_i, ones_i} >= max_i) begin
                tens_o = 4'd0;
                ones_o = 4'd0;
            end else if (ones_i == 4'd9) begin
                tens_o = tens_i + 4'd1;
                ones_o = 4'd0;
            end else begin
                ones_o = ones_i + 4'd1;
            end
        end
    end

endmodule

// File: rtl/rtc_set_ctrl.sv
// Time-set sequencer: mode button walks HR/MIN/SEC, inc/dec edit a shadow, COMMIT loads it.
// Optional inactivity abort enabled by defining RTC_SET_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | counters run, shadow idle, buttons other than mode ignored
// SET_HR  | editing hours field, hours digits blink
// SET_MIN | editing minutes field, minute digits blink
// SET_SEC | editing seconds field, second digits blink
// COMMIT  | one cycle: load strobe with shadow on set_time
module rtc_set_ctrl
    import rtc_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick_1hz,
    input  logic        tick_2hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [19:0] cur_time,
    output logic [19:0] set_time,
    output logic        load,
    output logic        set_active,
    output logic [5:0]  blank,
    output logic        timeout
);

    rtc_state_t state_q, state_d;
    rtc_time_t  shadow_q, shadow_d;
    logic       phase_q, phase_d;
    logic       load_q, load_d;
    logic       active_q, active_d;
    logic [5:0] blank_q, blank_d;
    logic       timeout_q, timeout_d;

    logic       in_field;
    logic       edit_ok;
    logic [3:0] fld_tens, fld_ones, step_tens, step_ones;
    logic [7:0] fld_max;

    assign in_field = (state_q == SET_HR) || (state_q == SET_MIN) || (state_q == SET_SEC);
    // Mode wins over an edit in the same cycle; inc together with dec cancels
    assign edit_ok  = in_field && !btn_mode && (btn_inc ^ btn_dec);

    always_comb begin
        fld_tens = 4'd0;
        fld_ones = 4'd0;
        fld_max  = MS_MAX;
        case (state_q)
            SET_HR: begin
                fld_tens = {2'b00, shadow_q.hr1};
                fld_ones = shadow_q.hr0;
                fld_max  = HR_MAX;
            end
            SET_MIN: begin
                fld_tens = {1'b0, shadow_q.min1};
                fld_ones = shadow_q.min0;
            end
            SET_SEC: begin
                fld_tens = {1'b0, shadow_q.sec1};
                fld_ones = shadow_q.sec0;
            end
            default: ;
        endcase
    end

    rtc_bcd_step u_step (
        .tens_i (fld_tens),
        .ones_i (fld_ones),
        .max_i  (fld_max),
        .dec_i  (btn_dec),
        .tens_o (step_tens),
        .ones_o (step_ones)
    );

`ifdef RTC_SET_TIMEOUT_EN
    logic [5:0] inact_q, inact_d;
    logic       expire;

    assign expire = in_field && (inact_q == 6'(TIMEOUT_S));

    always_comb begin
        inact_d = inact_q;
        if (!in_field || btn_mode || edit_ok) begin
            inact_d = 6'd0;
        end else if (tick_1hz) begin
            inact_d = inact_q + 6'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) inact_q <= 6'd0;
        else     inact_q <= inact_d;
    end

    logic unused_step;
    assign unused_step = step_tens[3];
`else
    logic expire;
    assign expire = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^{tick_1hz, step_tens[3], 32'(TIMEOUT_S)};
`endif

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: if (btn_mode) begin
                shadow_d = rtc_time_t'(cur_time);
                state_d  = SET_HR;
            end
            SET_HR:  if (btn_mode) state_d = SET_MIN;
            SET_MIN: if (btn_mode) state_d = SET_SEC;
            SET_SEC: if (btn_mode) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (edit_ok) begin
            case (state_q)
                SET_HR: begin
                    shadow_d.hr1 = step_tens[1:0];
                    shadow_d.hr0 = step_ones;
                end
                SET_MIN: begin
                    shadow_d.min1 = step_tens[2:0];
                    shadow_d.min0 = step_ones;
                end
                SET_SEC: begin
                    shadow_d.sec1 = step_tens[2:0];
                    shadow_d.sec0 = step_ones;
                end
                default: ;
            endcase
        end

        if (expire) begin
            state_d   = IDLE;
            shadow_d  = '0;
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        phase_d = phase_q;
        if (state_d != state_q || !in_field || edit_ok) begin
            phase_d = 1'b0;
        end else if (tick_2hz) begin
            phase_d = ~phase_q;
        end

        blank_d = 6'b0;
        case (state_d)
            SET_HR: begin
                blank_d[BLK_H0] = phase_d;
                blank_d[BLK_H1] = phase_d;
            end
            SET_MIN: begin
                blank_d[BLK_M0] = phase_d;
                blank_d[BLK_M1] = phase_d;
            end
            SET_SEC: begin
                blank_d[BLK_S0] = phase_d;
                blank_d[BLK_S1] = phase_d;
            end
            default: ;
        endcase

        load_d   = (state_d == COMMIT);
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            phase_q   <= 1'b0;
            load_q    <= 1'b0;
            active_q  <= 1'b0;
            blank_q   <= 6'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            phase_q   <= phase_d;
            load_q    <= load_d;
            active_q  <= active_d;
            blank_q   <= blank_d;
            timeout_q <= timeout_d;
        end
    end

    assign set_time   = shadow_q;
    assign load       = load_q;
    assign set_active = active_q;
    assign blank      = blank_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_rtc_set_ctrl.sv
// Directed bench for rtc_set_ctrl: entry, BCD wrap edits, blink, commit, reset and timeout.
module tb_rtc_set_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_1hz = 1'b0;
    logic        tick_2hz = 1'b0;
    logic        btn_mode = 1'b0;
    logic        btn_inc = 1'b0;
    logic        btn_dec = 1'b0;
    logic [19:0] cur_time = 20'd0;
    logic [19:0] set_time;
    logic        load;
    logic        set_active;
    logic [5:0]  blank;
    logic        timeout;

    int checks = 0;
    int failures = 0;

    rtc_set_ctrl #(.TIMEOUT_S(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .tick_2hz   (tick_2hz),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .cur_time   (cur_time),
        .set_time   (set_time),
        .load       (load),
        .set_active (set_active),
        .blank      (blank),
        .timeout    (timeout)
    );

    always #10 clk = ~clk;

    function automatic logic [19:0] mk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return {h[5:4], h[3:0], m[6:4], m[3:0], s[6:4], s[3:0]};
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock edge, then sample 1 time unit after it
    task automatic pulse(input logic m, input logic i, input logic d, input logic t1, input logic t2);
        btn_mode = m; btn_inc = i; btn_dec = d; tick_1hz = t1; tick_2hz = t2;
        @(posedge clk); #1;
        btn_mode = 0; btn_inc = 0; btn_dec = 0; tick_1hz = 0; tick_2hz = 0;
    endtask

    task automatic outs(input string tag, input logic l, input logic a, input logic [5:0] b, input logic t);
        chk({tag, ".load"}, 20'(load), 20'(l));
        chk({tag, ".active"}, 20'(set_active), 20'(a));
        chk({tag, ".blank"}, 20'(blank), 20'(b));
        chk({tag, ".timeout"}, 20'(timeout), 20'(t));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        outs("reset", 0, 0, 6'b0, 0);
        chk("reset.time", set_time, 20'd0);

        cur_time = mk(8'h12, 8'h34, 8'h56);
        pulse(1, 0, 0, 0, 0);
        outs("enter", 0, 1, 6'b0, 0);
        chk("enter.time", set_time, mk(8'h12, 8'h34, 8'h56));
        pulse(0, 0, 0, 0, 1);
        chk("hr.blink_on", 20'(blank), 20'h03);
        pulse(0, 0, 0, 0, 1);
        chk("hr.blink_off", 20'(blank), 20'h00);

        repeat (11) pulse(0, 1, 0, 0, 0);
        chk("hr.to23", set_time, mk(8'h23, 8'h34, 8'h56));
        pulse(0, 0, 0, 0, 1);
        pulse(0, 1, 0, 0, 0);
        chk("hr.wrap_up", set_time, mk(8'h00, 8'h34, 8'h56));
        chk("hr.edit_unblank", 20'(blank), 20'h00);
        pulse(0, 0, 1, 0, 0);
        chk("hr.wrap_dn", set_time, mk(8'h23, 8'h34, 8'h56));

        pulse(1, 0, 0, 0, 0);
        outs("min.entry", 0, 1, 6'b0, 0);
        repeat (4) pulse(0, 0, 1, 0, 0);
        chk("min.to30", set_time, mk(8'h23, 8'h30, 8'h56));
        pulse(0, 1, 1, 0, 0);
        chk("min.incdec", set_time, mk(8'h23, 8'h30, 8'h56));
        pulse(0, 0, 0, 0, 1);
        chk("min.blink1", 20'(blank), 20'(6'b001100));
        pulse(0, 0, 0, 0, 1);
        chk("min.blink2", 20'(blank), 20'(6'b000000));
        pulse(0, 0, 0, 0, 1);
        chk("min.blink3", 20'(blank), 20'(6'b001100));
        pulse(0, 0, 0, 0, 1);
        chk("min.blink4", 20'(blank), 20'(6'b000000));
        pulse(0, 0, 0, 0, 1);
        pulse(0, 1, 0, 0, 0);
        chk("min.edit_unblank", 20'(blank), 20'h00);
        chk("min.inc31", set_time, mk(8'h23, 8'h31, 8'h56));
        pulse(0, 0, 1, 0, 0);

        pulse(1, 1, 0, 0, 0);
        chk("modeinc.min", set_time, mk(8'h23, 8'h30, 8'h56));
        pulse(0, 0, 0, 0, 1);
        chk("sec.blink", 20'(blank), 20'(6'b110000));

        repeat (3) pulse(0, 1, 0, 0, 0);
        chk("sec.to59", set_time, mk(8'h23, 8'h30, 8'h59));
        pulse(0, 1, 0, 0, 0);
        chk("sec.wrap_up", set_time, mk(8'h23, 8'h30, 8'h00));
        pulse(0, 0, 1, 0, 0);
        chk("sec.wrap_dn", set_time, mk(8'h23, 8'h30, 8'h59));
        pulse(0, 1, 0, 0, 0);
        repeat (10) pulse(0, 1, 0, 0, 0);
        chk("sec.carry10", set_time, mk(8'h23, 8'h30, 8'h10));

        pulse(1, 0, 0, 0, 0);
        outs("commit", 1, 1, 6'b0, 0);
        chk("commit.time", set_time, mk(8'h23, 8'h30, 8'h10));
        pulse(1, 0, 0, 0, 0);
        outs("post_commit", 0, 0, 6'b0, 0);
        pulse(0, 1, 0, 0, 0);
        chk("idle.inc_ignored", set_time, mk(8'h23, 8'h30, 8'h10));

        cur_time = mk(8'h07, 8'h08, 8'h09);
        pulse(1, 0, 0, 0, 0);
        pulse(0, 1, 0, 0, 0);
        chk("edit2.hr", set_time, mk(8'h08, 8'h08, 8'h09));
`ifdef RTC_SET_TIMEOUT_EN
        repeat (3) pulse(0, 0, 0, 1, 0);
        outs("pre_timeout", 0, 1, 6'b0, 0);
        @(posedge clk); #1;
        outs("timeout", 0, 0, 6'b0, 1);
        chk("timeout.time", set_time, 20'd0);
        @(posedge clk); #1;
        outs("post_timeout", 0, 0, 6'b0, 0);
        pulse(1, 0, 0, 0, 0);
`else
        repeat (5) pulse(0, 0, 0, 1, 0);
        outs("no_timeout", 0, 1, 6'b0, 0);
`endif
        pulse(0, 0, 0, 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        outs("mid_reset", 0, 0, 6'b0, 0);
        chk("mid_reset.time", set_time, 20'd0);
        @(posedge clk); #1;
        outs("after_reset", 0, 0, 6'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
